// File: rtl/fifo_rd_stream.sv
// Read-side adapter from a synchronous FIFO with one-cycle read latency to a
// valid/ready stream. A 2-entry skid buffer absorbs the in-flight read.
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_cs,
    output logic                  fifo_rd_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]  xfer_cnt,
    output logic                  busy
);

    logic [1:0]            count;
    logic                  inflight;
    logic [DATA_WIDTH-1:0] slot0;
    logic [DATA_WIDTH-1:0] slot1;
    logic                  pop;
    logic [2:0]            level;

    // Outputs are forced quiet during the reset cycle itself, not just after it.
    assign out_valid  = !rst && (count != 2'd0);
    assign out_data   = rst ? '0 : slot0;
    assign busy       = !rst && ((count != 2'd0) || inflight);
    assign pop        = out_valid && out_ready;
    assign fifo_rd_cs = enable;

    // Occupancy after this cycle, counting the word already requested.
    assign level      = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign fifo_rd_en = !rst && enable && !fifo_empty && (level < 3'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= 2'd0;
            inflight <= 1'b0;
            xfer_cnt <= '0;
            slot0    <= '0;
            slot1    <= '0;
        end else begin
            inflight <= fifo_rd_en;
            xfer_cnt <= xfer_cnt + CNT_WIDTH'(pop);
            unique case ({inflight, pop})
                2'b10: begin
                    if (count == 2'd0) slot0 <= fifo_data;
                    else               slot1 <= fifo_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Head leaves while a new word lands; occupancy is unchanged.
                    if (count == 2'd1) begin
                        slot0 <= fifo_data;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= fifo_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: FIFO model feeds words, a scoreboard
// queue holds expected stream order, and a monitor checks every accepted word.
module tb_fifo_rd_stream;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_rd_cs;
    logic       fifo_rd_en;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [3:0] xfer_cnt;
    logic       busy;

    int         total = 0;
    int         passed = 0;
    logic [7:0] exp_q[$];

    logic [7:0] mem[0:63];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic       flush = 1'b0;

    fifo_rd_stream #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_cs (fifo_rd_cs),
        .fifo_rd_en (fifo_rd_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .xfer_cnt   (xfer_cnt),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Upstream synchronous FIFO: read data registered one cycle after rd_en.
    assign fifo_empty = (rd_ptr == wr_ptr);
    always @(posedge clk) begin
        if (flush) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_rd_en) begin
            fifo_data <= mem[rd_ptr[5:0]];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL out_data: unexpected word %0h at %0t", out_data, $time);
            end else begin
                chk("out_data order", {24'h0, out_data}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic load(input logic [7:0] d, input bit expect_it);
        mem[wr_ptr[5:0]] = d;
        wr_ptr++;
        if (expect_it) exp_q.push_back(d);
    endtask

    task automatic start_test();
        rst       = 1'b1;
        enable    = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        exp_q.delete();
    endtask

    task automatic release_rst();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || !fifo_empty) && n < max_cycles);
        chk("drain timeout busy", busy, 0);
    endtask

    initial begin
        logic [5:0] e_rd;
        logic [5:0] e_vld;
        int         rdcnt;

        rst       = 1'b1;
        enable    = 1'b0;
        out_ready = 1'b0;

        // Reset dominates even with data available and enable high
        start_test();
        load(8'hAA, 1'b0);
        enable    = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("reset out_valid", out_valid, 0);
        chk("reset busy", busy, 0);
        chk("reset rd_en", fifo_rd_en, 0);
        chk("reset out_data", out_data, 0);
        chk("reset xfer_cnt", xfer_cnt, 0);

        // Three-word stream, latency and throughput
        start_test();
        load(8'h11, 1'b1); load(8'h22, 1'b1); load(8'h33, 1'b1);
        enable    = 1'b1;
        out_ready = 1'b1;
        release_rst();
        e_rd  = 6'b000111;
        e_vld = 6'b011100;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("basic rd_en c%0d", c), fifo_rd_en, e_rd[c]);
            chk($sformatf("basic out_valid c%0d", c), out_valid, e_vld[c]);
        end
        chk("basic busy end", busy, 0);
        chk("basic xfer_cnt", xfer_cnt, 3);

        // Backpressure: two reads only, head stable, then gapless resume
        start_test();
        for (int i = 0; i < 5; i++) load(8'h41 + 8'(i), 1'b1);
        enable = 1'b1;
        release_rst();
        rdcnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (fifo_rd_en) rdcnt++;
            if (c >= 3) begin
                chk("stall out_valid", out_valid, 1);
                chk("stall out_data hold", out_data, 8'h41);
            end
        end
        chk("stall rd_en pulses", rdcnt, 2);
        @(posedge clk);
        #1 out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("resume no gap c%0d", c), out_valid, 1);
        end
        @(negedge clk);
        chk("resume done out_valid", out_valid, 0);
        chk("resume xfer_cnt", xfer_cnt, 5);

        // Toggling out_ready while streaming 0x01..0x08
        start_test();
        for (int i = 1; i <= 8; i++) load(8'(i), 1'b1);
        enable    = 1'b1;
        out_ready = 1'b1;
        release_rst();
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1 out_ready = ~out_ready;
        end
        out_ready = 1'b1;
        wait_idle(50);
        chk("toggle xfer_cnt", xfer_cnt, 8);
        chk("toggle all delivered", exp_q.size(), 0);

        // Enable dropped right after one read
        start_test();
        load(8'h61, 1'b1); load(8'h62, 1'b0); load(8'h63, 1'b0);
        enable    = 1'b1;
        out_ready = 1'b1;
        release_rst();
        @(negedge clk);
        chk("disable first rd_en", fifo_rd_en, 1);
        @(posedge clk);
        #1 enable = 1'b0;
        rdcnt = 0;
        for (int c = 1; c < 7; c++) begin
            @(negedge clk);
            if (fifo_rd_en) rdcnt++;
            if (c == 1) chk("disable busy inflight", busy, 1);
            if (c == 3) chk("disable busy drained", busy, 0);
        end
        chk("disable no more rd_en", rdcnt, 0);
        chk("disable rd_cs", fifo_rd_cs, 0);
        chk("disable xfer_cnt", xfer_cnt, 1);
        chk("disable word delivered", exp_q.size(), 0);

        // Reset with one word buffered and one in flight
        start_test();
        load(8'h71, 1'b0); load(8'h72, 1'b0);
        enable = 1'b1;
        release_rst();
        @(negedge clk);
        chk("rst-flight rd_en c0", fifo_rd_en, 1);
        @(negedge clk);
        chk("rst-flight rd_en c1", fifo_rd_en, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("in-reset out_valid", out_valid, 0);
        chk("in-reset rd_en", fifo_rd_en, 0);
        chk("in-reset busy", busy, 0);
        chk("in-reset out_data", out_data, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("post-reset out_valid c%0d", c), out_valid, 0);
        end
        chk("post-reset xfer_cnt", xfer_cnt, 0);
        chk("post-reset busy", busy, 0);

        // 17 words through a 4-bit counter
        start_test();
        for (int i = 0; i < 17; i++) load(8'h80 + 8'(i), 1'b1);
        enable    = 1'b1;
        out_ready = 1'b1;
        release_rst();
        wait_idle(60);
        chk("wrap xfer_cnt", xfer_cnt, 1);
        chk("wrap all delivered", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d", passed, total);
        $fatal(1, "watchdog");
    end

endmodule
